// File: rtl/pri_enc_pkg.sv
// pri_enc_pkg
//   Shared types and helpers for the serial priority encoder.
//   - state_t   : FSM state encoding (IDLE, DRAIN, ZERO)
//   - pick_oh   : one-hot of the winning set bit (highest or lowest index)
//   - oh2idx    : one-hot to binary index
//   - is_single : vector has exactly one bit set
//   Helpers work on a MAX_N-wide vector; callers zero-extend narrower vectors.
package pri_enc_pkg;

   localparam int MAX_N = 64;
   localparam int IDX_W = $clog2(MAX_N);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      ZERO  = 2'd2
   } state_t;

   // The last matching index written wins, so the scan direction sets the priority.
   function automatic logic [MAX_N-1:0] pick_oh(input logic [MAX_N-1:0] vec,
                                                input logic             lsb_first);
      logic [MAX_N-1:0] res;
      int               j;
      res = '0;
      for (int i = 0; i < MAX_N; i++) begin
         j = lsb_first ? (MAX_N - 1 - i) : i;
         if (vec[j]) begin
            res    = '0;
            res[j] = 1'b1;
         end
      end
      return res;
   endfunction

   function automatic logic [IDX_W-1:0] oh2idx(input logic [MAX_N-1:0] onehot);
      logic [IDX_W-1:0] res;
      res = '0;
      for (int i = 0; i < MAX_N; i++) begin
         if (onehot[i]) res = res | IDX_W'(i);
      end
      return res;
   endfunction

   function automatic logic is_single(input logic [MAX_N-1:0] vec);
      return (vec != '0) && ((vec & (vec - MAX_N'(1))) == '0);
   endfunction

endpackage

// File: rtl/pri_pick.sv
// pri_pick
//   Combinational priority picker: request vector -> one-hot winner, its
//   binary index, and a flag that exactly one request is set.
//   Parameters: N (vector width, 2..64), LSB_FIRST (0: highest index wins).
//   Ports:
//     vec     in   N  request vector
//     onehot  out  N  one-hot of winning bit (0 when vec is 0)
//     idx     out  W  index of winning bit (0 when vec is 0)
//     single  out  1  vec has exactly one bit set
module pri_pick
   import pri_enc_pkg::*;
#(
   parameter  int N         = 8,
   parameter  bit LSB_FIRST = 1'b0,
   localparam int W         = $clog2(N)
) (
   input  logic [N-1:0] vec,
   output logic [N-1:0] onehot,
   output logic [W-1:0] idx,
   output logic         single
);

   logic [MAX_N-1:0] vec_ext;
   logic [MAX_N-1:0] oh_ext;
   logic             unused_bits;

   assign vec_ext = MAX_N'(vec);
   assign oh_ext  = pick_oh(vec_ext, LSB_FIRST);
   assign onehot  = oh_ext[N-1:0];
   assign idx     = W'(oh2idx(oh_ext));
   assign single  = is_single(vec_ext);

   // Bits above N are always zero because vec is zero-extended.
   assign unused_bits = ^oh_ext;

endmodule

// File: rtl/pri_encoder_serial.sv
// pri_encoder_serial
//   Accepts an N-bit request vector and emits the index of every set bit,
//   one per output beat, in priority order, flagging the final beat.
//   Parameters: N (2..64), LSB_FIRST (0: highest index first, 1: lowest first).
//   Optional build macro PRI_ENC_SER_ZERO_BEAT_EN: an accepted all-zero vector
//   produces one beat with out_none=1; without it the vector is silently dropped.
//   Ports:
//     clk, rst_n              clock, async active-low reset
//     in_valid/in_ready/in_vec  input handshake and request vector
//     out_valid/out_ready       output handshake
//     out_idx, out_onehot       current winning bit (index and one-hot)
//     out_last                  final beat of the current vector
//     out_none                  empty-vector beat (macro builds only)
//     busy                      FSM not idle
//
// state | meaning
// IDLE  | no pending bits, ready for a vector
// DRAIN | emitting pending bits, one per transfer
// ZERO  | emitting the single empty-vector beat (macro builds only)
module pri_encoder_serial
   import pri_enc_pkg::*;
#(
   parameter  int N         = 8,
   parameter  bit LSB_FIRST = 1'b0,
   localparam int W         = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_vec,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_idx,
   output logic [N-1:0] out_onehot,
   output logic         out_last,
   output logic         out_none,
   output logic         busy
);

   state_t       state, state_nxt;
   logic [N-1:0] pend, pend_nxt;
   logic [N-1:0] pick_onehot;
   logic [W-1:0] pick_idx;
   logic         pick_single;
   logic         ready_int;

   pri_pick #(
      .N         (N),
      .LSB_FIRST (LSB_FIRST)
   ) u_pick (
      .vec    (pend),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .single (pick_single)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         pend  <= '0;
      end else begin
         state <= state_nxt;
         pend  <= pend_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pend_nxt  = pend;
      ready_int = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      out_none  = 1'b0;

      case (state)
         IDLE: begin
            ready_int = 1'b1;
         end
         DRAIN: begin
            out_valid = 1'b1;
            out_last  = pick_single;
            if (out_ready) begin
               pend_nxt = pend & ~pick_onehot;
               if (pick_single) begin
                  state_nxt = IDLE;
                  ready_int = 1'b1;
               end
            end
         end
`ifdef PRI_ENC_SER_ZERO_BEAT_EN
         ZERO: begin
            out_valid = 1'b1;
            out_none  = 1'b1;
            out_last  = 1'b1;
            if (out_ready) begin
               state_nxt = IDLE;
               ready_int = 1'b1;
            end
         end
`endif
         default: begin
            state_nxt = IDLE;
            pend_nxt  = '0;
         end
      endcase

      // A new vector may load on the same edge as the last-beat transfer.
      if (in_valid && ready_int) begin
         if (in_vec != '0) begin
            pend_nxt  = in_vec;
            state_nxt = DRAIN;
         end else begin
            pend_nxt  = '0;
`ifdef PRI_ENC_SER_ZERO_BEAT_EN
            state_nxt = ZERO;
`else
            state_nxt = IDLE;
`endif
         end
      end
   end

   assign in_ready   = ready_int & rst_n;
   assign out_onehot = (state == DRAIN) ? pick_onehot : '0;
   assign out_idx    = (state == DRAIN) ? pick_idx : '0;
   assign busy       = (state != IDLE);

endmodule

// File: tb/tb_pri_encoder_serial.sv
module tb_pri_encoder_serial;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic        iv8, ir8, ov8, ordy8, ol8, on8, bz8;
   logic [7:0]  ivec8, ooh8;
   logic [2:0]  oidx8;

   logic        iv16, ir16, ov16, ordy16, ol16, on16, bz16;
   logic [15:0] ivec16, ooh16;
   logic [3:0]  oidx16;

   pri_encoder_serial #(.N(8), .LSB_FIRST(1'b0)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .in_vec(ivec8),
      .out_valid(ov8), .out_ready(ordy8), .out_idx(oidx8), .out_onehot(ooh8),
      .out_last(ol8), .out_none(on8), .busy(bz8));

   pri_encoder_serial #(.N(16), .LSB_FIRST(1'b1)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .in_vec(ivec16),
      .out_valid(ov16), .out_ready(ordy16), .out_idx(oidx16), .out_onehot(ooh16),
      .out_last(ol16), .out_none(on16), .busy(bz16));

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int idx;
      bit last;
      bit none;
   } beat_t;

   beat_t q[2][$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: an accepted vector becomes the list of its set-bit
   // indices in priority order; the DUT must present that list beat by beat.
   task automatic mon(input int d, input int n, input bit lsb,
                      input logic iv, input logic [15:0] ivec, input logic ordy,
                      input logic ir, input logic ov, input logic [3:0] oidx,
                      input logic [15:0] ooh, input logic ol, input logic on,
                      input logic bz);
      beat_t       b;
      int          idxs[$];
      bit          exp_rdy;
      logic [15:0] exp_oh;
      int          i;
      if (!rst_n) begin
         chk($sformatf("d%0d_rst_out_valid", d), 32'(ov), 32'd0);
         chk($sformatf("d%0d_rst_in_ready", d), 32'(ir), 32'd0);
         q[d].delete();
         return;
      end
      exp_rdy = (q[d].size() == 0) || (q[d].size() == 1 && ordy);
      chk($sformatf("d%0d_out_valid", d), 32'(ov), 32'(q[d].size() != 0));
      chk($sformatf("d%0d_in_ready", d), 32'(ir), 32'(exp_rdy));
      chk($sformatf("d%0d_busy", d), 32'(bz), 32'(q[d].size() != 0));
      if (ov && q[d].size() != 0) begin
         b      = q[d][0];
         exp_oh = b.none ? 16'h0 : (16'h1 << b.idx);
         chk($sformatf("d%0d_out_idx", d), 32'(oidx), 32'(b.idx));
         chk($sformatf("d%0d_out_onehot", d), 32'(ooh), 32'(exp_oh));
         chk($sformatf("d%0d_out_last", d), 32'(ol), 32'(b.last));
         chk($sformatf("d%0d_out_none", d), 32'(on), 32'(b.none));
         if (ordy) void'(q[d].pop_front());
      end
      if (iv && exp_rdy) begin
         for (int k = 0; k < n; k++) begin
            i = lsb ? k : (n - 1 - k);
            if (ivec[i]) idxs.push_back(i);
         end
         if (idxs.size() == 0) begin
`ifdef PRI_ENC_SER_ZERO_BEAT_EN
            q[d].push_back('{0, 1'b1, 1'b1});
`endif
         end else begin
            foreach (idxs[j]) q[d].push_back('{idxs[j], (j == idxs.size() - 1), 1'b0});
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0, 8, 1'b0, iv8, {8'h00, ivec8}, ordy8, ir8, ov8, {1'b0, oidx8},
          {8'h00, ooh8}, ol8, on8, bz8);
      mon(1, 16, 1'b1, iv16, ivec16, ordy16, ir16, ov16, oidx16, ooh16, ol16, on16, bz16);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] rvec(input int n);
      logic [31:0] mask;
      mask = (32'h1 << n) - 32'h1;
      case ($urandom_range(0, 3))
         0:       return 16'h0;
         1:       return 16'(32'h1 << $urandom_range(0, n - 1));
         default: return 16'($urandom() & mask);
      endcase
   endfunction

   initial begin
      int exp7521[4];
      exp7521 = '{7, 5, 2, 1};
      rst_n = 1'b0;
      iv8 = 0; ivec8 = '0; ordy8 = 0;
      iv16 = 0; ivec16 = '0; ordy16 = 0;
      #3;
      chk("reset_out_valid", 32'(ov8), 0);
      chk("reset_in_ready", 32'(ir8), 0);
      chk("reset_out_idx", 32'(oidx8), 0);
      chk("reset_out_onehot", 32'(ooh8), 0);
      chk("reset_out_last", 32'(ol8), 0);
      chk("reset_out_none", 32'(on8), 0);
      chk("reset_busy", 32'(bz8), 0);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // A6, MSB first, consumer always ready
      iv8 = 1; ivec8 = 8'hA6; ordy8 = 1;
      tick();
      iv8 = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("a6_seq_idx", 32'(oidx8), 32'(exp7521[k]));
         chk("a6_seq_last", 32'(ol8), 32'(k == 3));
         tick();
      end
      tick();

      // backpressure at index 5
      iv8 = 1; ivec8 = 8'hA6; ordy8 = 1;
      tick();
      iv8 = 0;
      tick();
      ordy8 = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_idx", 32'(oidx8), 32'd5);
         chk("bp_onehot", 32'(ooh8), 32'h20);
         chk("bp_last", 32'(ol8), 32'd0);
         chk("bp_valid", 32'(ov8), 32'd1);
         tick();
      end
      ordy8 = 1;
      repeat (4) tick();

      // back-to-back 81 then 10
      iv8 = 1; ivec8 = 8'h81; ordy8 = 1;
      tick();
      ivec8 = 8'h10;
      tick();
      tick();
      iv8 = 0;
      @(negedge clk);
      chk("b2b_idx", 32'(oidx8), 32'd4);
      chk("b2b_last", 32'(ol8), 32'd1);
      tick();
      tick();

      // empty vector
      iv8 = 1; ivec8 = 8'h00;
      tick();
      iv8 = 0;
      @(negedge clk);
`ifdef PRI_ENC_SER_ZERO_BEAT_EN
      chk("zero_busy", 32'(bz8), 32'd1);
      chk("zero_none", 32'(on8), 32'd1);
      chk("zero_last", 32'(ol8), 32'd1);
`else
      chk("zero_busy", 32'(bz8), 32'd0);
      chk("zero_valid", 32'(ov8), 32'd0);
`endif
      tick(); tick();

      // reset in the middle of a drain
      iv8 = 1; ivec8 = 8'hA6; ordy8 = 1;
      tick();
      iv8 = 0;
      tick();
      #1;
      rst_n = 1'b0;
      #1;
      chk("middrain_rst_valid", 32'(ov8), 32'd0);
      chk("middrain_rst_busy", 32'(bz8), 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", 32'(ir8), 32'd1);
      chk("post_rst_valid", 32'(ov8), 32'd0);
      tick(); tick();

      // N=16 LSB first
      iv16 = 1; ivec16 = 16'h8001; ordy16 = 1;
      tick();
      iv16 = 0;
      @(negedge clk);
      chk("n16_idx0", 32'(oidx16), 32'd0);
      chk("n16_oh0", 32'(ooh16), 32'h0001);
      chk("n16_last0", 32'(ol16), 32'd0);
      tick();
      @(negedge clk);
      chk("n16_idx1", 32'(oidx16), 32'd15);
      chk("n16_oh1", 32'(ooh16), 32'h8000);
      chk("n16_last1", 32'(ol16), 32'd1);
      tick(); tick();

      // random traffic on both instances
      for (int c = 0; c < 600; c++) begin
         iv8    = 1'($urandom_range(0, 1));
         ivec8  = 8'(rvec(8));
         ordy8  = ($urandom_range(0, 3) != 0);
         iv16   = 1'($urandom_range(0, 1));
         ivec16 = rvec(16);
         ordy16 = ($urandom_range(0, 3) != 0);
         tick();
      end
      iv8 = 0; iv16 = 0; ordy8 = 1; ordy16 = 1;
      repeat (40) tick();
      chk("drain_empty_n8", 32'(q[0].size()), 32'd0);
      chk("drain_empty_n16", 32'(q[1].size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
